// File: rtl/ball_hit_demux.sv
// Per-pixel collision resolver: maps shot/player collisions back to the owning ball
// (priority big ball 1 > big ball 2 > huge ball) and reports at start of frame.
module ball_hit_demux #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             startOfFrame,
  input  logic             hugeBallRequest,
  input  logic             bigBall1Request,
  input  logic             bigBall2Request,
  input  logic             shotRequest,
  input  logic             playerRequest,
  output logic             shotClear,
  output logic             hugeBallHit,
  output logic             bigBall1Hit,
  output logic             bigBall2Hit,
  output logic             playerHit,
  output logic [CNT_W-1:0] hitCount
);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    LOCKED  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // One-hot owner, bit order {huge, big2, big1}; same priority as the draw merger
  function automatic logic [2:0] owner_decode(input logic big1, input logic big2,
                                              input logic huge);
    if (big1) begin
      owner_decode = 3'b001;
    end else if (big2) begin
      owner_decode = 3'b010;
    end else if (huge) begin
      owner_decode = 3'b100;
    end else begin
      owner_decode = 3'b000;
    end
  endfunction

  state_t     state_r;
  state_t     state_nxt_s;
  logic [2:0] owner_s;
  logic       shot_col_s;
  logic       player_col_s;
  logic       take_shot_s;
  logic [2:0] owner_flag_r;
  logic [2:0] owner_flag_nxt_s;
  logic       player_flag_r;
  logic       player_flag_nxt_s;

  assign owner_s      = owner_decode(bigBall1Request, bigBall2Request, hugeBallRequest);
  assign shot_col_s   = shotRequest && (owner_s != 3'b000);
  assign player_col_s = playerRequest &&
                        (hugeBallRequest || bigBall1Request || bigBall2Request);

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r <= COLLECT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a report returns to COLLECT unless the same cycle takes a hit
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      COLLECT: begin
        if (take_shot_s) begin
          state_nxt_s = LOCKED;
        end else begin
          state_nxt_s = COLLECT;
        end
      end
      LOCKED: begin
        if (take_shot_s) begin
          state_nxt_s = LOCKED;
        end else if (startOfFrame) begin
          state_nxt_s = COLLECT;
        end else begin
          state_nxt_s = LOCKED;
        end
      end
      default: state_nxt_s = COLLECT;
    endcase
  end

  // Output/flag logic; startOfFrame opens a fresh frame so a coincident shot is accepted
  always_comb begin
    take_shot_s       = 1'b0;
    owner_flag_nxt_s  = owner_flag_r;
    player_flag_nxt_s = player_flag_r;
    if (startOfFrame) begin
      take_shot_s = shot_col_s;
    end else if (state_r == COLLECT) begin
      take_shot_s = shot_col_s;
    end else begin
      take_shot_s = 1'b0;
    end
    if (take_shot_s) begin
      owner_flag_nxt_s = owner_s;
    end else if (startOfFrame) begin
      owner_flag_nxt_s = 3'b000;
    end else begin
      owner_flag_nxt_s = owner_flag_r;
    end
    if (startOfFrame) begin
      player_flag_nxt_s = player_col_s;
    end else begin
      player_flag_nxt_s = player_flag_r || player_col_s;
    end
  end

  // Flags and registered report outputs
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      owner_flag_r  <= 3'b000;
      player_flag_r <= 1'b0;
      shotClear     <= 1'b0;
      bigBall1Hit   <= 1'b0;
      bigBall2Hit   <= 1'b0;
      hugeBallHit   <= 1'b0;
      playerHit     <= 1'b0;
      hitCount      <= {CNT_W{1'b0}};
    end else begin
      owner_flag_r  <= owner_flag_nxt_s;
      player_flag_r <= player_flag_nxt_s;
      shotClear     <= take_shot_s;
      bigBall1Hit   <= startOfFrame && owner_flag_r[0];
      bigBall2Hit   <= startOfFrame && owner_flag_r[1];
      hugeBallHit   <= startOfFrame && owner_flag_r[2];
      playerHit     <= startOfFrame && player_flag_r;
      if (startOfFrame && (owner_flag_r != 3'b000) && (hitCount != CNT_MAX)) begin
        hitCount <= hitCount + CNT_W'(1);
      end else begin
        hitCount <= hitCount;
      end
    end
  end

endmodule

// File: doc/ball_hit_demux.md
# ball_hit_demux

Per-pixel collision resolver on the return path of the ball drawing chain. Ball draw requests are merged into a single request with fixed priority (big ball 1 > big ball 2 > huge ball); this block performs the inverse routing. It watches the per-ball requests against the shot and player draw requests, works out which ball owns each colliding pixel under that same priority, and latches at most one shot hit per frame. It reports per-ball hit pulses, a player-hit pulse and a running hit count to the game controller at start of frame.

## Interface
Parameters:
- CNT_W, 8, width of hitCount; saturates at 2^CNT_W-1.

Ports:
- clk  input  1  system clock. Single clock domain.
- resetN  input  1  reset; asynchronous and active-low.
- startOfFrame  input  1  one-cycle pulse, first clock of each frame.
- hugeBallRequest  input  1  huge ball draws the current pixel.
- bigBall1Request  input  1  big ball 1 draws the current pixel.
- bigBall2Request  input  1  big ball 2 draws the current pixel.
- shotRequest  input  1  shot draws the current pixel.
- playerRequest  input  1  player draws the current pixel.
- shotClear  output  1  one-cycle pulse the cycle after the first shot hit of a frame is latched.
- hugeBallHit  output  1  one-cycle report pulse.
- bigBall1Hit  output  1  one-cycle report pulse.
- bigBall2Hit  output  1  one-cycle report pulse.
- playerHit  output  1  one-cycle report pulse.
- hitCount  output  CNT_W  number of reported ball hits since reset, saturating.

## Operation
- Owner decode is combinational, per cycle:
  - owner = BIG1 if bigBall1Request.
  - else owner = BIG2 if bigBall2Request.
  - else owner = HUGE if hugeBallRequest.
  - else NONE.
- shotCol = shotRequest && owner != NONE.
- playerCol = playerRequest && (any ball request).
- FSM has two states:
  - COLLECT: on shotCol, latch a one-hot ownerFlag[2:0] for the owner, pulse shotClear next cycle, go to LOCKED.
  - LOCKED: further shotCol events are ignored and produce no shotClear and no flag change.
- playerFlag is sticky within the frame. It is set on any playerCol in either state.
- startOfFrame acts as the report event:
  - Next cycle, drive hugeBallHit/bigBall1Hit/bigBall2Hit from ownerFlag and playerHit from playerFlag, each for exactly one cycle.
  - hitCount increments by 1 if any ownerFlag bit is set, and holds at max.
  - Then clear ownerFlag and playerFlag and return to COLLECT.
- startOfFrame coincident with shotCol or playerCol:
  - The report uses the flags as they were before that cycle.
  - The coincident collision is latched into the new frame (ownerFlag set, state LOCKED, shotClear pulse next cycle).
- Multiple balls overlapping the shot on the same pixel: only the highest-priority ball is flagged. The at-most-one-ball-hit-per-frame rule always holds.
- Reset values: state COLLECT, ownerFlag 0, playerFlag 0, all pulse outputs 0, hitCount 0. Reset mid-frame discards latched flags; no report is generated for that frame.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- shotClear is high on cycle N+1 for a shotCol sampled at posedge N.
- Report pulses and the hitCount update appear at N+1 for startOfFrame sampled at N. hitCount is stable from then until the next report.
- At most one of the three ball hit pulses is high in any cycle. All pulses are exactly one cycle wide.
- No backpressure: the consumer must sample report pulses on the cycle they are high.

## Test plan
- Reset, then shotRequest=1 with hugeBallRequest=1 for one cycle mid-frame:
  - shotClear high for 1 cycle next clock.
  - At next startOfFrame, hugeBallHit=1 for 1 cycle and hitCount=1.
- shot, bigBall1Request and bigBall2Request all high in the same cycle, followed by a later cycle with shot and huge high, then startOfFrame:
  - Only bigBall1Hit pulses.
  - Only one shotClear in the frame.
  - hitCount +1.
- playerRequest and bigBall2Request high with no shot, then startOfFrame:
  - playerHit=1 and all ball hit pulses 0.
  - hitCount unchanged.
- startOfFrame in the same cycle as shot+bigBall2Request, with bigBall1 already latched earlier:
  - Report is bigBall1Hit.
  - shotClear is pulsed.
  - Next frame's report is bigBall2Hit.
- CNT_W=2 with 5 reported hits: hitCount reads 1, 2, 3, 3, 3.
- Latch a hit, assert resetN=0 mid-frame, release, then startOfFrame: no hit pulses and hitCount=0.
